note_player: RTL and testbench
==============================

Name: note_player

Overview:
- Downstream stage of the song sequencer.
- Accepts one note at a time (note, duration, voicing) on a load strobe and synthesizes 16-bit signed sine samples at the pitch given by the note number.
- Counts the note's duration in beat pulses and raises note_done when it expires, which the sequencer consumes to advance.
- Samples feed the codec/mixer path on request via generate_next_sample.

Parameters:
- PHASE_W, 22, phase accumulator width
- STEP_W, 20, frequency step width from frequency ROM
- SAMPLE_W, 16, signed output sample width

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- play  in  1  high = run; low = pause (freeze duration and phase)
- note  in  6  note number; 0 = rest, 1 = A1 (55 Hz), semitone steps, 37 = A4 (440 Hz)
- duration  in  6  note length in beats
- voicing  in  3  timbre select; used only with VOICING_EN
- load_new_note  in  1  one-cycle strobe; latch note/duration/voicing
- beat  in  1  one-cycle pulse, 48 per second
- generate_next_sample  in  1  one-cycle request for next sample (48 kHz)
- sample_out  out  16  signed sample
- new_sample_ready  out  1  one-cycle pulse, sample_out valid
- note_done  out  1  one-cycle pulse when current note's duration expires

Behaviour:
- Reset values:
  - State IDLE.
  - sample_out, new_sample_ready, note_done, phase, beat counter, and latched note/duration/voicing are all 0.
- States:
  - IDLE: no active note.
  - ACTIVE: counting beats.
- Transitions:
  - IDLE -> ACTIVE on load_new_note.
  - ACTIVE -> ACTIVE on load_new_note: restart; phase reset to 0; counter reloaded.
  - ACTIVE -> IDLE on an expiring beat.
- Load:
  - On load_new_note, latch note, duration and voicing; counter := duration; phase := 0.
  - load_new_note is accepted regardless of play.
- Duration:
  - On beat with play=1 in ACTIVE: if counter <= 1, assert note_done on the next cycle for exactly 1 cycle and go to IDLE; else counter -= 1.
  - Duration 0 and 1 both expire on the first beat.
- Beat is ignored when play=0 or in IDLE.
- Simultaneous load_new_note and beat: load wins, the beat is discarded, and note_done is not raised that cycle.
- Frequency:
  - Combinational frequency ROM (64 entries) gives step = round(f * 2^22 / 48000); entry 0 = 0.
  - Note 37 gives step 38448.
- Phase:
  - On generate_next_sample with play=1 and ACTIVE: phase := phase + step, modulo 2^22 (wraps silently).
  - Otherwise phase is held.
- Sine lookup:
  - phase[21:20] = quadrant; phase[19:10] = address into a 1024-entry quarter-wave ROM (registered, 1-cycle read).
  - Quadrants 1 and 3 mirror the address (1023 - addr); quadrants 2 and 3 negate the value.
- Latency:
  - new_sample_ready pulses exactly 2 cycles after each generate_next_sample, unconditionally (including IDLE, paused, and rest).
  - sample_out updates on the same edge as new_sample_ready.
- Rest, IDLE, or play=0 at request time: sample_out = 0.
- Back-to-back generate_next_sample on consecutive cycles is legal; the pipeline yields consecutive new_sample_ready pulses.
- Mid-operation reset: return to reset values on the next edge; any in-flight sample is dropped (no new_sample_ready).

Optional Feature:
- VOICING_EN defined: final sample = sine >>> voicing[1:0] (arithmetic shift, attenuation). voicing[2] = 1 adds a second harmonic: a second phase accumulator at 2x step, output (fund >>> 1) + (harm >>> 1) before attenuation.
- VOICING_EN undefined: voicing is latched but unused; output is the pure sine.

Decomposition:
- Shared package:
  - NOTE_WIDTH = 6, DURATION_WIDTH = 6, VOICING_WIDTH = 3.
  - PHASE_W, STEP_W, SAMPLE_W.
  - State encodings IDLE and ACTIVE.
  - The 48 kHz / 48-beat constants.
- Sub-module sine_reader: phase accumulator + quarter-wave ROM + quadrant logic.
  - Inputs: step, generate_next_sample, enable, clear.
  - Outputs: sample, sample_ready.
  - Instantiated twice under VOICING_EN.
- frequency_rom is a separate ROM module.

Test Plan:
- Reset: hold reset 3 cycles -> all outputs 0. One generate_next_sample pulse -> new_sample_ready 2 cycles later with sample_out = 0.
- Load note 37, duration 3, play=1, issue 3 beats -> note_done single pulse the cycle after the 3rd beat, not before. Phase after 4 generate_next_sample pulses = 153792.
- Load note 0, duration 2 -> all samples 0, note_done after 2nd beat.
- Note 37, duration 4: after 1 beat drop play for 5 beats + 10 sample requests -> phase unchanged, samples 0. Restore play -> note_done after 3 further beats.
- load_new_note (duration 2) asserted same cycle as the expiring beat of the prior note -> no note_done that cycle, counter = 2, note_done after 2 more beats.
- VOICING_EN, voicing = 3'b010, note 37 -> every sample equals the non-VOICING_EN value >>> 2. Peak magnitude <= 8191.

Source files
------------

// File: rtl/note_player_pkg.sv
// Shared types, widths and constant-table generators for the note_player block.
// The VOICING_EN build macro is consumed by note_player.sv only.
package note_player_pkg;

  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int VOICING_WIDTH  = 3;
  localparam int PHASE_W        = 22;
  localparam int STEP_W         = 20;
  localparam int SAMPLE_W       = 16;

  localparam int SAMPLE_RATE_HZ = 48000;
  localparam int BEATS_PER_SEC  = 48;

  localparam int QW_ADDR_W = 10;
  localparam int QW_DEPTH  = 1024;
  localparam int ROM_W     = SAMPLE_W - 1;
  localparam int AMPLITUDE = 32767;

  localparam int     FP_FRAC = 30;
  localparam longint FP_ONE  = 64'sd1073741824;
  localparam longint PI_Q30  = 64'sd3373259426;
  localparam longint A1_HZ   = 64'sd55;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

  function automatic longint fp_mul(input longint a, input longint b);
    return (a * b) >>> FP_FRAC;
  endfunction

  // Table entries sample the middle of each step: sin((2a+1)*pi/4096), so mirroring is exact.
  function automatic logic [ROM_W-1:0] quarter_sine(input int addr);
    longint x;
    longint x2;
    longint term;
    longint sum;
    x    = (longint'(2 * addr + 1) * PI_Q30) / 64'sd4096;
    x2   = fp_mul(x, x);
    term = x;
    sum  = x;
    for (int k = 1; k <= 8; k++) begin
      term = -fp_mul(term, x2) / longint'((2 * k) * (2 * k + 1));
      sum  = sum + term;
    end
    return ROM_W'((sum * longint'(AMPLITUDE) + (FP_ONE >>> 1)) >>> FP_FRAC);
  endfunction

  function automatic longint root12_q30();
    longint lo;
    longint hi;
    longint mid;
    longint m4;
    longint m12;
    lo = FP_ONE;
    hi = FP_ONE * 64'sd2;
    for (int i = 0; i < 32; i++) begin
      mid = (lo + hi) >>> 1;
      m4  = fp_mul(fp_mul(mid, mid), fp_mul(mid, mid));
      m12 = fp_mul(fp_mul(m4, m4), m4);
      if (m12 > FP_ONE * 64'sd2) hi = mid;
      else lo = mid;
    end
    return lo;
  endfunction

  // step = round(f * 2^22 / 48000) with f = 55 Hz * 2^((n-1)/12); note 0 is a rest.
  function automatic logic [STEP_W-1:0] freq_step(input int n, input longint root);
    longint v;
    longint num;
    longint den;
    int     e;
    if (n == 0) return '0;
    e = n - 1;
    v = A1_HZ * FP_ONE;
    for (int s = 0; s < e % 12; s++) v = fp_mul(v, root);
    num = v <<< (e / 12);
    den = longint'(SAMPLE_RATE_HZ) * 64'sd256;
    return STEP_W'((num + (den >>> 1)) / den);
  endfunction

endpackage

// File: rtl/frequency_rom.sv
// Combinational note-number to phase-step table, contents built at elaboration.
module frequency_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_WIDTH-1:0] note_i,
  output logic [STEP_W-1:0]     step_o
);

  localparam longint ROOT = root12_q30();

  logic [STEP_W-1:0] rom_s [2**NOTE_WIDTH];

  for (genvar i = 0; i < 2**NOTE_WIDTH; i++) begin : g_entry
    localparam logic [STEP_W-1:0] STEP = freq_step(i, ROOT);
    assign rom_s[i] = STEP;
  end

  assign step_o = rom_s[note_i];

endmodule

// File: rtl/note_player_sine_reader.sv
// Phase accumulator feeding a registered quarter-wave sine ROM; the sample
// emerges one cycle after the request, the caller adds the output register.
module sine_reader
  import note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic [STEP_W-1:0]          step_i,
  input  logic                       generate_next_sample_i,
  input  logic                       enable_i,
  input  logic                       clear_i,
  output logic signed [SAMPLE_W-1:0] sample_o,
  output logic                       sample_ready_o
);

  logic [PHASE_W-1:0]   phase_q, phase_d;
  logic [1:0]           quad_s;
  logic [QW_ADDR_W-1:0] addr_s, rom_addr_s;
  logic [ROM_W-1:0]     rom_s [QW_DEPTH];
  logic [ROM_W-1:0]     rom_data_q;
  logic                 negate_q, mute_q, ready_q;

  for (genvar i = 0; i < QW_DEPTH; i++) begin : g_rom
    localparam logic [ROM_W-1:0] VAL = quarter_sine(i);
    assign rom_s[i] = VAL;
  end

  assign quad_s     = phase_q[PHASE_W-1 -: 2];
  assign addr_s     = phase_q[PHASE_W-3 -: QW_ADDR_W];
  assign rom_addr_s = quad_s[0] ? ~addr_s : addr_s;

  always_comb begin
    phase_d = phase_q;
    if (clear_i) phase_d = '0;
    else if (generate_next_sample_i && enable_i) phase_d = phase_q + PHASE_W'(step_i);
    else phase_d = phase_q;
  end

  // Lookup uses the phase before this request's advance; mute is decided at request time.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q    <= '0;
      rom_data_q <= '0;
      negate_q   <= 1'b0;
      mute_q     <= 1'b0;
      ready_q    <= 1'b0;
    end else begin
      phase_q <= phase_d;
      ready_q <= generate_next_sample_i;
      if (generate_next_sample_i) begin
        rom_data_q <= rom_s[rom_addr_s];
        negate_q   <= quad_s[1];
        mute_q     <= !enable_i || (step_i == '0);
      end else begin
        rom_data_q <= rom_data_q;
        negate_q   <= negate_q;
        mute_q     <= mute_q;
      end
    end
  end

  always_comb begin
    sample_o = '0;
    if (mute_q) sample_o = '0;
    else if (negate_q) sample_o = -$signed({1'b0, rom_data_q});
    else sample_o = $signed({1'b0, rom_data_q});
  end

  assign sample_ready_o = ready_q;

endmodule

// File: rtl/note_player.sv
// Note player: beat-counted note duration plus on-demand sine synthesis.
// Define VOICING_EN to enable attenuation and the second-harmonic voice.
module note_player
  import note_player_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       play,
  input  logic [NOTE_WIDTH-1:0]      note,
  input  logic [DURATION_WIDTH-1:0]  duration,
  input  logic [VOICING_WIDTH-1:0]   voicing,
  input  logic                       load_new_note,
  input  logic                       beat,
  input  logic                       generate_next_sample,
  output logic signed [SAMPLE_W-1:0] sample_out,
  output logic                       new_sample_ready,
  output logic                       note_done
);

  state_e                    state_q, state_d;
  logic [NOTE_WIDTH-1:0]     note_q, note_d;
  logic [DURATION_WIDTH-1:0] cnt_q, cnt_d;
  logic [VOICING_WIDTH-1:0]  voicing_q, voicing_d;
  logic                      note_done_d;
  logic                      enable_s;
  logic [STEP_W-1:0]         step_s;
  logic signed [SAMPLE_W-1:0] fund_s, final_s;
  logic                      fund_ready_s;

  assign enable_s = play && (state_q == ACTIVE);

  frequency_rom u_freq (
    .note_i (note_q),
    .step_o (step_s)
  );

  sine_reader u_fund (
    .clk                    (clk),
    .reset                  (reset),
    .step_i                 (step_s),
    .generate_next_sample_i (generate_next_sample),
    .enable_i               (enable_s),
    .clear_i                (load_new_note),
    .sample_o               (fund_s),
    .sample_ready_o         (fund_ready_s)
  );

`ifdef VOICING_EN
  logic [STEP_W-1:0]          harm_step_s;
  logic signed [SAMPLE_W-1:0] harm_s, mix_s;
  logic                       harm_ready_unused_s;

  assign harm_step_s = {step_s[STEP_W-2:0], 1'b0};

  sine_reader u_harm (
    .clk                    (clk),
    .reset                  (reset),
    .step_i                 (harm_step_s),
    .generate_next_sample_i (generate_next_sample),
    .enable_i               (enable_s),
    .clear_i                (load_new_note),
    .sample_o               (harm_s),
    .sample_ready_o         (harm_ready_unused_s)
  );

  always_comb begin
    mix_s = fund_s;
    if (voicing_q[2]) mix_s = (fund_s >>> 1) + (harm_s >>> 1);
    else mix_s = fund_s;
    final_s = mix_s >>> voicing_q[1:0];
  end
`else
  logic voicing_unused_s;

  assign voicing_unused_s = ^voicing_q;
  assign final_s          = fund_s;
`endif

  // A load always wins over a coincident beat, so the old note never reports done.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    note_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load_new_note) state_d = ACTIVE;
        else state_d = IDLE;
      end
      ACTIVE: begin
        if (load_new_note) begin
          state_d = ACTIVE;
        end else if (beat && play) begin
          if (cnt_q <= 6'd1) begin
            state_d     = IDLE;
            cnt_d       = '0;
            note_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end else begin
          state_d = ACTIVE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (load_new_note) begin
      note_d    = note;
      voicing_d = voicing;
      cnt_d     = duration;
    end else begin
      note_d    = note_q;
      voicing_d = voicing_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= IDLE;
      note_q           <= '0;
      cnt_q            <= '0;
      voicing_q        <= '0;
      sample_out       <= '0;
      new_sample_ready <= 1'b0;
      note_done        <= 1'b0;
    end else begin
      state_q          <= state_d;
      note_q           <= note_d;
      cnt_q            <= cnt_d;
      voicing_q        <= voicing_d;
      new_sample_ready <= fund_ready_s;
      note_done        <= note_done_d;
      if (fund_ready_s) sample_out <= final_s;
      else sample_out <= sample_out;
    end
  end

endmodule

// File: tb/tb_note_player.sv
// Directed bench for note_player with an ideal-sine reference model checked every cycle.
module tb_note_player;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play = 1'b0;
  logic [5:0] note = 6'd0;
  logic [5:0] duration = 6'd0;
  logic [2:0] voicing = 3'd0;
  logic load_new_note = 1'b0;
  logic beat = 1'b0;
  logic generate_next_sample = 1'b0;
  logic signed [15:0] sample_out;
  logic new_sample_ready;
  logic note_done;

`ifdef VOICING_EN
  localparam int TOL  = 2;
  localparam int PEAK = 8191;
`else
  localparam int TOL  = 1;
  localparam int PEAK = 32767;
`endif
  localparam real PI = 3.14159265358979;

  int errors = 0;
  int checks = 0;
  bit checking = 1'b0;
  int done_count = 0;
  int rdy_count = 0;
  int nonzero_count = 0;
  bit track_peak = 1'b0;
  int peak = 0;

  // reference model state
  bit m_rdy = 1'b0, m_done = 1'b0, m_s1_rdy = 1'b0, m_active = 1'b0;
  int m_smp = 0, m_s1_smp = 0, m_phase = 0, m_note = 0, m_cnt = 0;
  logic [2:0] m_voicing = 3'd0;

  note_player dut (
    .clk                  (clk),
    .reset                (reset),
    .play                 (play),
    .note                 (note),
    .duration             (duration),
    .voicing              (voicing),
    .load_new_note        (load_new_note),
    .beat                 (beat),
    .generate_next_sample (generate_next_sample),
    .sample_out           (sample_out),
    .new_sample_ready     (new_sample_ready),
    .note_done            (note_done)
  );

  always #5 clk = ~clk;

  function automatic int note_step(input int n);
    real f;
    if (n == 0) return 0;
    f = 55.0 * $pow(2.0, real'(n - 1) / 12.0);
    return $rtoi(f * 4194304.0 / 48000.0 + 0.5);
  endfunction

  function automatic int ideal_sine(input int ph);
    real v;
    v = 32767.0 * $sin(2.0 * PI * (real'(ph >>> 10) + 0.5) / 4096.0);
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(-v + 0.5);
  endfunction

  function automatic int voiced(input int ph, input logic [2:0] v);
    int fund;
    fund = ideal_sine(ph);
`ifdef VOICING_EN
    begin
      int mix;
      int harm;
      harm = ideal_sine((2 * ph) % 4194304);
      mix  = v[2] ? ((fund >>> 1) + (harm >>> 1)) : fund;
      return mix >>> v[1:0];
    end
`else
    return fund;
`endif
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    checks++;
    if (act - exp > tol || exp - act > tol) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step();
    if (reset) begin
      m_rdy = 1'b0; m_smp = 0; m_done = 1'b0; m_s1_rdy = 1'b0; m_s1_smp = 0;
      m_phase = 0; m_note = 0; m_cnt = 0; m_active = 1'b0; m_voicing = 3'd0;
      return;
    end
    if (m_s1_rdy) m_smp = m_s1_smp;
    m_rdy  = m_s1_rdy;
    m_done = 1'b0;
    m_s1_rdy = generate_next_sample;
    if (generate_next_sample)
      m_s1_smp = (m_active && play && m_note != 0) ? voiced(m_phase, m_voicing) : 0;
    if (load_new_note) begin
      m_note = int'(note); m_cnt = int'(duration); m_voicing = voicing;
      m_phase = 0; m_active = 1'b1;
    end else begin
      if (generate_next_sample && play && m_active)
        m_phase = (m_phase + note_step(m_note)) % 4194304;
      if (beat && play && m_active) begin
        if (m_cnt <= 1) begin
          m_active = 1'b0; m_done = 1'b1; m_cnt = 0;
        end else begin
          m_cnt--;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Compare DUT against model on every falling edge.
  initial forever begin
    @(negedge clk);
    if (checking) begin
      check("new_sample_ready", int'(new_sample_ready), int'(m_rdy), 0);
      check("note_done", int'(note_done), int'(m_done), 0);
      check("sample_out", int'(sample_out), m_smp, TOL);
      if (note_done) done_count++;
      if (new_sample_ready) begin
        rdy_count++;
        if (sample_out != 16'sd0) nonzero_count++;
        if (track_peak) begin
          if (sample_out > peak) peak = int'(sample_out);
          if (-sample_out > peak) peak = -int'(sample_out);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic gens(input int n);
    for (int i = 0; i < n; i++) begin
      generate_next_sample = 1'b1;
      cyc(1);
    end
    generate_next_sample = 1'b0;
  endtask

  task automatic pulse_beat();
    beat = 1'b1;
    cyc(1);
    beat = 1'b0;
  endtask

  task automatic load(input int n, input int d, input logic [2:0] v);
    note = 6'(n); duration = 6'(d); voicing = v;
    load_new_note = 1'b1;
    cyc(1);
    load_new_note = 1'b0;
  endtask

  initial begin
    int d0;
    int r0;
    int z0;
    cyc(1);
    checking = 1'b1;
    cyc(2);
    check("reset_sample", int'(sample_out), 0, 0);
    reset = 1'b0;
    r0 = rdy_count;
    gens(1);
    cyc(3);
    check("idle_ready_count", rdy_count - r0, 1, 0);
    check("idle_sample", int'(sample_out), 0, 0);

    check("model_step37", note_step(37), 38448, 0);
    check("model_sine0", ideal_sine(0), 25, 0);
    check("model_sine_q1", ideal_sine(1024 << 10), 32767, 0);

    // note 37, duration 3
    play = 1'b1;
    d0 = done_count;
    load(37, 3, 3'b000);
    gens(4);
    check("model_phase4", m_phase, 153792, 0);
    gens(20);
    cyc(3);
    pulse_beat(); cyc(2);
    pulse_beat(); cyc(2);
    check("done_before_3rd", done_count - d0, 0, 0);
    pulse_beat(); cyc(3);
    check("done_after_3rd", done_count - d0, 1, 0);

    // rest note
    d0 = done_count; z0 = nonzero_count;
    load(0, 2, 3'b000);
    gens(6); cyc(3);
    pulse_beat(); cyc(2);
    check("rest_done_early", done_count - d0, 0, 0);
    pulse_beat(); cyc(3);
    check("rest_done", done_count - d0, 1, 0);
    check("rest_nonzero", nonzero_count - z0, 0, 0);

    // pause
    d0 = done_count;
    load(37, 4, 3'b000);
    gens(5); cyc(2);
    pulse_beat(); cyc(1);
    play = 1'b0;
    z0 = nonzero_count;
    for (int i = 0; i < 5; i++) begin
      pulse_beat();
      gens(2);
    end
    cyc(3);
    check("pause_nonzero", nonzero_count - z0, 0, 0);
    check("pause_done", done_count - d0, 0, 0);
    play = 1'b1;
    gens(5); cyc(3);
    pulse_beat(); cyc(1);
    pulse_beat(); cyc(2);
    check("resume_done_early", done_count - d0, 0, 0);
    pulse_beat(); cyc(3);
    check("resume_done", done_count - d0, 1, 0);

    // load coincident with expiring beat
    d0 = done_count;
    load(37, 3, 3'b000);
    pulse_beat(); cyc(1);
    pulse_beat(); cyc(1);
    note = 6'd37; duration = 6'd2;
    load_new_note = 1'b1; beat = 1'b1;
    cyc(1);
    load_new_note = 1'b0; beat = 1'b0;
    cyc(3);
    check("collide_no_done", done_count - d0, 0, 0);
    pulse_beat(); cyc(2);
    check("collide_one_beat", done_count - d0, 0, 0);
    pulse_beat(); cyc(3);
    check("collide_done", done_count - d0, 1, 0);

    // another pitch
    load(49, 3, 3'b000);
    gens(30); cyc(3);

    // attenuation voicing
    load(37, 8, 3'b010);
    peak = 0; track_peak = 1'b1;
    gens(60); cyc(3);
    track_peak = 1'b0;
    check("peak_bound", int'(peak <= PEAK), 1, 0);
    check("peak_level", peak, PEAK, PEAK / 16);
    load(37, 8, 3'b100);
    gens(30); cyc(3);

    // mid-operation reset drops the in-flight sample
    load(37, 8, 3'b000);
    gens(3); cyc(3);
    r0 = rdy_count;
    gens(1);
    reset = 1'b1;
    cyc(2);
    reset = 1'b0;
    cyc(3);
    check("inflight_dropped", rdy_count - r0, 0, 0);
    check("post_reset_sample", int'(sample_out), 0, 0);
    gens(2); cyc(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
